// File: rtl/rv_csr_sequencer_if.sv
// Command channel from the execute stage into the CSR/trap sequencer.
// Valid/ready handshake; a command transfers on valid & ready.
interface rv_csr_sequencer_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i;
    logic [11:0] cmd_adr_i;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_op1_i;
    logic        cmd_x0_i;
    logic [4:0]  cmd_rd_i;
    logic [29:0] cmd_pc_i;

    modport master (
        output cmd_valid_i, cmd_type_i, cmd_adr_i, cmd_op_i, cmd_op1_i,
               cmd_x0_i, cmd_rd_i, cmd_pc_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_type_i, cmd_adr_i, cmd_op_i, cmd_op1_i,
               cmd_x0_i, cmd_rd_i, cmd_pc_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/rv_csr_sequencer.sv
// Machine-mode SYSTEM command sequencer between execute stage and CSR unit.
// Latency: CSR 2 cycles to writeback, trap 2 cycles to redirect, MRET 1 cycle.
// Backpressure: one command in flight; ready only in IDLE with no pending interrupt.
module rv_csr_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    rv_csr_sequencer_if.slave cmd,
    output logic        csr_ce_o,
    output logic [11:0] csr_adr_o,
    output logic [1:0]  csr_op_o,
    output logic [31:0] csr_op1_o,
    output logic        csr_x0_o,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        csr_exception_i,
    output logic        mtrap_strobe_o,
    output logic [3:0]  mcause_o,
    output logic [29:0] mepc_o,
    output logic        cmd_tret_o,
    input  logic        interrupt_exec_i,
    output logic        interrupt_ack_o,
    input  logic [29:0] next_pc_i,
    input  logic [29:0] mtvec_i,
    input  logic [29:0] mepc_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_adr_o,
    output logic [31:0] rd_wdata_o,
    output logic        redirect_o,
    output logic [29:0] redirect_pc_o
);
    localparam logic [3:0] CAUSE_ILLEGAL = 4'h2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'h3;
    localparam logic [3:0] CAUSE_ECALL   = 4'hB;

    localparam logic [1:0] TYPE_CSR    = 2'b00;
    localparam logic [1:0] TYPE_ECALL  = 2'b01;
    localparam logic [1:0] TYPE_EBREAK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_TRAP, S_REDIR, S_RET
    } state_t;

    state_t      state_q;
    logic [11:0] adr_q;
    logic [1:0]  op_q;
    logic [31:0] op1_q;
    logic        x0_q;
    logic [4:0]  rd_q;
    logic [29:0] pc_q;     // command PC, or next_pc_i when taking an interrupt
    logic [3:0]  cause_q;
    logic        irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            op_q    <= '0;
            op1_q   <= '0;
            x0_q    <= 1'b0;
            rd_q    <= '0;
            pc_q    <= '0;
            cause_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (interrupt_exec_i) begin
                        irq_q   <= 1'b1;
                        pc_q    <= next_pc_i;
                        cause_q <= 4'h0;
                        state_q <= S_TRAP;
                    end else if (cmd.cmd_valid_i) begin
                        adr_q <= cmd.cmd_adr_i;
                        op_q  <= cmd.cmd_op_i;
                        op1_q <= cmd.cmd_op1_i;
                        x0_q  <= cmd.cmd_x0_i;
                        rd_q  <= cmd.cmd_rd_i;
                        pc_q  <= cmd.cmd_pc_i;
                        case (cmd.cmd_type_i)
                            TYPE_CSR: begin
                                if (cmd.cmd_op_i == 2'b00) begin
                                    cause_q <= CAUSE_ILLEGAL;
                                    state_q <= S_TRAP;
                                end else begin
                                    state_q <= S_ISSUE;
                                end
                            end
                            TYPE_ECALL: begin
                                cause_q <= CAUSE_ECALL;
                                state_q <= S_TRAP;
                            end
                            TYPE_EBREAK: begin
                                cause_q <= CAUSE_EBREAK;
                                state_q <= S_TRAP;
                            end
                            default: state_q <= S_RET;
                        endcase
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    // A writeback wins if the CSR unit ever flags both at once.
                    if (csr_we_i) begin
                        state_q <= S_IDLE;
                    end else if (csr_exception_i) begin
                        cause_q <= CAUSE_ILLEGAL;
                        state_q <= S_TRAP;
                    end
                end
                S_TRAP:  state_q <= S_REDIR;
                S_REDIR: begin
                    irq_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_RET:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic in_access;
    logic wb_hit;
    assign in_access = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign wb_hit    = (state_q == S_WAIT) && csr_we_i;

    assign cmd.cmd_ready_o = (state_q == S_IDLE) && !interrupt_exec_i && !rst_i;

    assign csr_ce_o  = (state_q == S_ISSUE);
    assign csr_adr_o = in_access ? adr_q : '0;
    assign csr_op_o  = in_access ? op_q  : '0;
    assign csr_op1_o = in_access ? op1_q : '0;
    assign csr_x0_o  = in_access && x0_q;

    assign mtrap_strobe_o  = (state_q == S_TRAP);
    assign mcause_o        = (state_q == S_TRAP) ? cause_q : '0;
    assign mepc_o          = (state_q == S_TRAP) ? pc_q : '0;
    assign interrupt_ack_o = (state_q == S_TRAP) && irq_q;

    assign cmd_tret_o    = (state_q == S_RET);
    assign redirect_o    = (state_q == S_REDIR) || (state_q == S_RET);
    assign redirect_pc_o = (state_q == S_REDIR) ? mtvec_i :
                           (state_q == S_RET)   ? mepc_i  : '0;

    // Writeback is combinational on the CSR unit's response pulse.
    assign rd_we_o    = wb_hit && (rd_q != 5'd0);
    assign rd_adr_o   = wb_hit ? rd_q : '0;
    assign rd_wdata_o = wb_hit ? csr_wdata_i : '0;
endmodule
